// File: rtl/cs_arbiter_pkg.sv
// ============================================================================
// Module   : cs_arbiter_pkg
// Purpose  : Shared constants for the chip-select arbiter: requester count,
//            index width and FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cs_arbiter_pkg;

  localparam int NREQ  = 8;
  localparam int IDX_W = 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/cs_arbiter_if.sv
// ============================================================================
// Module   : cs_arbiter_if
// Purpose  : Request / chip-select bundle between the requesters and the
//            arbiter; master is the arbiter side, slave the requester side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cs_arbiter_if;
  import cs_arbiter_pkg::*;

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  cs;
  logic [IDX_W-1:0] sel;
  logic             en;
  logic             tmo;

  modport master (input req, output cs, output sel, output en, output tmo);
  modport slave  (output req, input cs, input sel, input en, input tmo);

endinterface

`default_nettype wire

// File: rtl/cs_dec3to8.sv
// ============================================================================
// Module   : cs_dec3to8
// Purpose  : Combinational 3-to-8 one-hot decoder with enable; all outputs
//            are zero while the enable is low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cs_dec3to8
  import cs_arbiter_pkg::*;
(
  input  wire logic [IDX_W-1:0] i_sel,
  input  wire logic             i_en,
  output logic      [NREQ-1:0]  o_cs
);

  always_comb begin
    o_cs = '0;
    if (i_en) begin
      o_cs[i_sel] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cs_arbiter.sv
// ============================================================================
// Module   : cs_arbiter
// Purpose  : 8-way round-robin chip-select arbiter with minimum hold time and
//            a one-cycle break-before-make gap between grants.
//            Optional forced release after TIMEOUT cycles: define CS_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cs_arbiter
  import cs_arbiter_pkg::*;
#(
  parameter int HOLD_MIN = 2,
  parameter int TIMEOUT  = 16
)(
  input  wire logic    clk,
  input  wire logic    rst_n,
  cs_arbiter_if.master bus
);

  localparam logic [7:0] c_hold_last = 8'(HOLD_MIN - 1);
  localparam logic [7:0] c_tmo_last  = 8'(TIMEOUT - 1);
  localparam logic [7:0] c_hold_sat  = 8'hFF;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_sel;
  logic [IDX_W-1:0] r_ptr;
  logic             r_en;
  logic [7:0]       r_hold;
  logic [IDX_W-1:0] w_win;
  logic [NREQ-1:0]  w_cs;

  // Scan from ptr+1 upward with wrap; descending offsets let the nearest hit win.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0]  req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    rr_pick = ptr;
    for (int off = NREQ; off >= 1; off--) begin
      idx = ptr + IDX_W'(off);
      if (req[idx]) begin
        rr_pick = idx;
      end
    end
  endfunction

  assign w_win = rr_pick(bus.req, r_ptr);

`ifdef CS_TIMEOUT_EN
  logic r_tmo;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_ptr   <= IDX_W'(NREQ - 1);
      r_en    <= 1'b0;
      r_hold  <= '0;
`ifdef CS_TIMEOUT_EN
      r_tmo   <= 1'b0;
`endif
    end else begin
`ifdef CS_TIMEOUT_EN
      r_tmo <= 1'b0;
`endif
      case (r_state)
        IDLE, GAP: begin
          if (|bus.req) begin
            r_state <= GRANT;
            r_sel   <= w_win;
            r_ptr   <= w_win;
            r_en    <= 1'b1;
            r_hold  <= '0;
          end else begin
            r_state <= IDLE;
          end
        end
        GRANT: begin
          if (r_hold != c_hold_sat) begin
            r_hold <= r_hold + 8'd1;
          end
          if (!bus.req[r_sel] && (r_hold >= c_hold_last)) begin
            r_state <= GAP;
            r_en    <= 1'b0;
          end
`ifdef CS_TIMEOUT_EN
          // Reached only with req[sel] still high, since TIMEOUT > HOLD_MIN.
          else if (r_hold == c_tmo_last) begin
            r_state <= GAP;
            r_en    <= 1'b0;
            r_tmo   <= 1'b1;
          end
`endif
        end
        default: begin
          r_state <= IDLE;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

  cs_dec3to8 u_dec (
    .i_sel (r_sel),
    .i_en  (r_en),
    .o_cs  (w_cs)
  );

  assign bus.cs  = w_cs;
  assign bus.sel = r_sel;
  assign bus.en  = r_en;

`ifdef CS_TIMEOUT_EN
  assign bus.tmo = r_tmo;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^c_tmo_last;
  assign bus.tmo = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cs_arbiter.sv
// ============================================================================
// Module   : tb_cs_arbiter
// Purpose  : Directed self-checking bench for cs_arbiter (HOLD_MIN=2,
//            TIMEOUT=16); timeout scenario follows CS_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cs_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  cs_arbiter_if bus ();

  cs_arbiter #(
    .HOLD_MIN (2),
    .TIMEOUT  (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Structural invariants sampled mid-cycle.
  always @(negedge clk) begin
    logic [7:0] exp_cs;
    exp_cs = bus.en ? (8'd1 << bus.sel) : 8'd0;
    check("inv_cs_eq_en_sel", bus.cs, exp_cs);
    check("inv_onehot0", 8'($onehot0(bus.cs)), 8'd1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    bus.req = 8'h00;
    step();
    step();
    check("rst_cs", bus.cs, 8'h00);
    check("rst_sel", 8'(bus.sel), 8'd0);
    check("rst_en", 8'(bus.en), 8'd0);
    check("rst_tmo", 8'(bus.tmo), 8'd0);
    rst_n = 1'b1;
    step();
    check("idle_en", 8'(bus.en), 8'd0);

    // Single requester, request dropped after first grant cycle.
    bus.req = 8'h04;
    step();
    check("single_c1_cs", bus.cs, 8'h04);
    check("single_c1_sel", 8'(bus.sel), 8'd2);
    bus.req = 8'h00;
    step();
    check("single_c2_cs", bus.cs, 8'h04);
    step();
    check("single_gap_cs", bus.cs, 8'h00);
    check("single_gap_en", 8'(bus.en), 8'd0);
    check("single_gap_sel", 8'(bus.sel), 8'd2);
    step();
    check("single_idle_cs", bus.cs, 8'h00);

    // Round robin from reset pointer: 0..7 then 0.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    bus.req = 8'hFF;
    for (int k = 0; k <= 8; k++) begin
      logic [7:0] onehot;
      onehot = 8'd1 << (k % 8);
      step();
      check($sformatf("rr%0d_c1_cs", k), bus.cs, onehot);
      check($sformatf("rr%0d_c1_sel", k), 8'(bus.sel), 8'(k % 8));
      step();
      check($sformatf("rr%0d_c2_cs", k), bus.cs, onehot);
      bus.req = 8'hFF & ~onehot;
      step();
      check($sformatf("rr%0d_gap_cs", k), bus.cs, 8'h00);
      bus.req = (k == 8) ? 8'h00 : 8'hFF;
    end
    step();
    check("rr_idle_en", 8'(bus.en), 8'd0);

    // Move pointer to 6.
    bus.req = 8'h40;
    step();
    check("ptr6_cs", bus.cs, 8'h40);
    step();
    bus.req = 8'h00;
    step();
    step();

    // Wrap-around: ptr=6, req=41 -> 0 then 6.
    bus.req = 8'h41;
    step();
    check("wrap_first_cs", bus.cs, 8'h01);
    step();
    bus.req = 8'h40;
    step();
    check("wrap_gap_cs", bus.cs, 8'h00);
    step();
    check("wrap_second_cs", bus.cs, 8'h40);
    check("wrap_second_sel", 8'(bus.sel), 8'd6);

    // No pre-emption while req[6] stays high.
    bus.req = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("nopreempt%0d_cs", k), bus.cs, 8'h40);
    end
    bus.req = 8'h00;
    step();
    check("nopreempt_gap_cs", bus.cs, 8'h00);
    step();

    // Reset mid-grant drops cs immediately.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    bus.req = 8'h10;
    step();
    check("rstmid_pre_cs", bus.cs, 8'h10);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_async_cs", bus.cs, 8'h00);
    check("rstmid_async_en", 8'(bus.en), 8'd0);
    step();
    rst_n = 1'b1;
    step();
    check("rstmid_regrant_cs", bus.cs, 8'h10);
    check("rstmid_regrant_sel", 8'(bus.sel), 8'd4);
    bus.req = 8'h00;
    step();
    step();
    step();

    // Long-held request: timeout build releases after 16 cycles.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    bus.req = 8'h03;
    step();
    check("hold_c1_cs", bus.cs, 8'h01);
`ifdef CS_TIMEOUT_EN
    for (int k = 2; k <= 16; k++) begin
      step();
      check($sformatf("tmo_c%0d_cs", k), bus.cs, 8'h01);
      check($sformatf("tmo_c%0d_tmo", k), 8'(bus.tmo), 8'd0);
    end
    step();
    check("tmo_gap_cs", bus.cs, 8'h00);
    check("tmo_gap_tmo", 8'(bus.tmo), 8'd1);
    step();
    check("tmo_next_cs", bus.cs, 8'h02);
    check("tmo_next_tmo", 8'(bus.tmo), 8'd0);
`else
    for (int k = 2; k <= 310; k++) begin
      step();
      check($sformatf("persist_c%0d_tmo", k), 8'(bus.tmo), 8'd0);
    end
    check("persist_cs", bus.cs, 8'h01);
    check("persist_en", 8'(bus.en), 8'd1);
`endif
    bus.req = 8'h00;
    step();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
